magic_nor_row_exec: RTL and testbench

Sequential executor for NOR-mapped netlists in the MAGIC in-memory style. It models one crossbar row as a bit-cell array and runs a loaded program of 2-input NOR operations, one per step, on each accepted input vector. It sits directly upstream of result capture and consumes the same single-output NOR netlists the flow emits (5-input benchmarks, NOT as self-NOR). Input vectors arrive on a valid/ready stream; one result bit leaves per vector.

---
 rtl/magic_nor_row_exec_pkg.sv | 23 ++
 rtl/magic_nor_row_exec_if.sv | 33 +++
 rtl/magic_nor_row_exec_imem.sv | 23 ++
 rtl/magic_nor_row_exec.sv | 127 ++++++++++++
 tb/tb_magic_nor_row_exec.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/magic_nor_row_exec_pkg.sv
// Shared types for the MAGIC NOR row executor: FSM states, the instruction word
// layout and its width.
package magic_pkg;

    localparam int unsigned DEF_CELLS = 32;
    localparam int unsigned DEF_IW    = $clog2(DEF_CELLS);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        EVAL,
        DONE
    } exec_state_e;

    typedef struct packed {
        logic [DEF_IW-1:0] dst;
        logic [DEF_IW-1:0] a;
        logic [DEF_IW-1:0] b;
    } nor_instr_t;

    localparam int unsigned INSTR_W = $bits(nor_instr_t);

endpackage

// File: rtl/magic_nor_row_exec_if.sv
// Program-load port plus input/result valid-ready streams of the row executor.
interface magic_nor_row_exec_if #(
    parameter int unsigned CELLS      = 32,
    parameter int unsigned NIN        = 5,
    parameter int unsigned PROG_DEPTH = 32
);
    localparam int unsigned IW = $clog2(CELLS);
    localparam int unsigned PW = $clog2(PROG_DEPTH);

    logic            prog_we;
    logic [PW-1:0]   prog_addr;
    logic [3*IW-1:0] prog_wdata;
    logic [PW:0]     prog_len;
    logic            in_valid;
    logic            in_ready;
    logic [NIN-1:0]  in_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_data;
    logic            busy;

    modport master (
        output prog_we, prog_addr, prog_wdata, prog_len,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  prog_we, prog_addr, prog_wdata, prog_len,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/magic_nor_row_exec_imem.sv
// Instruction store: synchronous write, combinational read, no reset so a
// loaded program survives rst.
module magic_imem #(
    parameter int unsigned PROG_DEPTH = 32,
    parameter int unsigned WIDTH      = 15
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(PROG_DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]              wdata,
    input  logic [$clog2(PROG_DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]              rdata
);
    logic [WIDTH-1:0] mem [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/magic_nor_row_exec.sv
// One crossbar row running a stored 2-input NOR program per input vector.
// MAGIC_INIT_EN: two-cycle gates (INIT sets dst to 1, EVAL conditionally resets).
module magic_nor_row_exec
    import magic_pkg::*;
#(
    parameter int unsigned CELLS      = 32,
    parameter int unsigned NIN        = 5,
    parameter int unsigned PROG_DEPTH = 32
) (
    input logic                 clk,
    input logic                 rst,
    magic_nor_row_exec_if.slave bus
);
    localparam int unsigned IW = $clog2(CELLS);
    localparam int unsigned PW = $clog2(PROG_DEPTH);

`ifdef MAGIC_INIT_EN
    localparam exec_state_e GATE_START = INIT;
`else
    localparam exec_state_e GATE_START = EVAL;
`endif

    exec_state_e     state;
    exec_state_e     state_nxt;
    logic [CELLS-1:0] cells;
    logic [PW-1:0]   pc;
    logic [PW:0]     len;
    logic            out_data_q;
    logic [3*IW-1:0] instr;
    logic [IW-1:0]   dst;
    logic [IW-1:0]   src_a;
    logic [IW-1:0]   src_b;
    logic            nor_val;
    logic            wr_val;
    logic            last;

    magic_imem #(
        .PROG_DEPTH(PROG_DEPTH),
        .WIDTH     (3*IW)
    ) u_imem (
        .clk  (clk),
        .we   (bus.prog_we && (state == IDLE)),
        .waddr(bus.prog_addr),
        .wdata(bus.prog_wdata),
        .raddr(pc),
        .rdata(instr)
    );

    assign dst     = instr[3*IW-1 -: IW];
    assign src_a   = instr[2*IW-1 -: IW];
    assign src_b   = instr[IW-1:0];
    assign nor_val = ~(cells[src_a] | cells[src_b]);
`ifdef MAGIC_INIT_EN
    // dst was preset to 1 by INIT, so an aliased source reads 1 and forces 0
    assign wr_val  = cells[dst] & nor_val;
`else
    assign wr_val  = nor_val;
`endif
    assign last    = (({1'b0, pc} + 1'b1) == len);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    state_nxt = (bus.prog_len == '0) ? DONE : GATE_START;
                end
            end
            INIT: state_nxt = EVAL;
            EVAL: state_nxt = last ? DONE : GATE_START;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cells      <= '0;
            pc         <= '0;
            len        <= '0;
            out_data_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cells <= {{(CELLS-NIN){1'b0}}, bus.in_data};
                        pc    <= '0;
                        len   <= bus.prog_len;
                        if (bus.prog_len == '0) begin
                            out_data_q <= 1'b0;
                        end
                    end
                end
                INIT: cells[dst] <= 1'b1;
                EVAL: begin
                    cells[dst] <= wr_val;
                    if (last) begin
                        out_data_q <= wr_val;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_data = out_data_q;
endmodule

// File: tb/tb_magic_nor_row_exec.sv
// Directed-vector bench for magic_nor_row_exec; expectations are hand-derived
// NOR evaluations of each small program.
module tb_magic_nor_row_exec;
    import magic_pkg::*;

`ifdef MAGIC_INIT_EN
    localparam int unsigned G         = 2;
    localparam logic        ALIAS_EXP = 1'b0;
`else
    localparam int unsigned G         = 1;
    localparam logic        ALIAS_EXP = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    magic_nor_row_exec_if #(.CELLS(32), .NIN(5), .PROG_DEPTH(32)) bus ();

    magic_nor_row_exec #(.CELLS(32), .NIN(5), .PROG_DEPTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_instr(input logic [4:0] addr, input nor_instr_t ins);
        @(negedge clk);
        bus.prog_we    = 1'b1;
        bus.prog_addr  = addr;
        bus.prog_wdata = ins;
        @(posedge clk);
        #1;
        bus.prog_we = 1'b0;
    endtask

    // Offer one vector and count edges after the accept edge until out_valid.
    task automatic start_run(input logic [4:0] din, input logic [5:0] len,
                             input int exp_lat, input string tag);
        int k;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = din;
        bus.prog_len = len;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq({tag, "_lat"}, k, exp_lat);
    endtask

    task automatic take_result(input logic exp, input int stall, input string tag);
        check_eq({tag, "_data"}, bus.out_data, exp);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_hold_valid"}, bus.out_valid, 1'b1);
            check_eq({tag, "_hold_data"}, bus.out_data, exp);
            check_eq({tag, "_hold_inrdy"}, bus.in_ready, 1'b0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_eq({tag, "_post_valid"}, bus.out_valid, 1'b0);
        check_eq({tag, "_post_inrdy"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        rst            = 1'b1;
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_wdata = '0;
        bus.prog_len   = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", bus.in_ready, 1'b1);
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_out_data", bus.out_data, 1'b0);
        check_eq("rst_busy", bus.busy, 1'b0);

        // Single NOR x0,x1 -> cell 5
        write_instr(5'd0, '{dst: 5'd5, a: 5'd0, b: 5'd1});
        start_run(5'b00000, 6'd1, G, "nor00");
        take_result(1'b1, 0, "nor00");
        start_run(5'b00010, 6'd1, G, "nor10");
        take_result(1'b0, 0, "nor10");

        // Double inversion of x2
        write_instr(5'd0, '{dst: 5'd6, a: 5'd2, b: 5'd2});
        write_instr(5'd1, '{dst: 5'd7, a: 5'd6, b: 5'd6});
        start_run(5'b00100, 6'd2, 2 * G, "buf1");
        take_result(1'b1, 0, "buf1");
        start_run(5'b00000, 6'd2, 2 * G, "buf0");
        take_result(1'b0, 5, "bp");

        // dst aliases source a
        write_instr(5'd0, '{dst: 5'd0, a: 5'd0, b: 5'd1});
        start_run(5'b00000, 6'd1, G, "alias");
        take_result(ALIAS_EXP, 0, "alias");

        // c5=~(x0|x1), c6=~(c5|x2), c7=~(c6|x3)
        write_instr(5'd0, '{dst: 5'd5, a: 5'd0, b: 5'd1});
        write_instr(5'd1, '{dst: 5'd6, a: 5'd5, b: 5'd2});
        write_instr(5'd2, '{dst: 5'd7, a: 5'd6, b: 5'd3});
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 5'b00000;
        bus.prog_len = 6'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (G) @(posedge clk);
        #1;
        check_eq("mid_busy", bus.busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_out_valid", bus.out_valid, 1'b0);
        check_eq("abort_in_ready", bus.in_ready, 1'b1);
        check_eq("abort_cells", dut.cells, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        start_run(5'b00000, 6'd3, 3 * G, "chain0");
        take_result(1'b1, 0, "chain0");
        start_run(5'b00011, 6'd3, 3 * G, "chain3");
        take_result(1'b0, 0, "chain3");
        start_run(5'b00000, 6'd3, 3 * G, "chain0b");
        take_result(1'b1, 0, "chain0b");

        // Zero-length run; a write while busy must not land in imem
        start_run(5'b11111, 6'd0, 0, "len0");
        @(negedge clk);
        bus.prog_we    = 1'b1;
        bus.prog_addr  = 5'd0;
        bus.prog_wdata = nor_instr_t'{dst: 5'd7, a: 5'd0, b: 5'd0};
        @(posedge clk);
        #1;
        bus.prog_we = 1'b0;
        check_eq("len0_still_valid", bus.out_valid, 1'b1);
        take_result(1'b0, 0, "len0");
        start_run(5'b00000, 6'd3, 3 * G, "imem_kept");
        take_result(1'b1, 0, "imem_kept");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
